// File: rtl/decode_ctrl_stage_if.sv
// Handshake and control-bundle signals between fetch, the decode stage and execute.
interface decode_ctrl_stage_if #(
  parameter int INSTR_W = 9,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction_in;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [REG_W-1:0]   read_reg0;
  logic [REG_W-1:0]   read_reg1;
  logic [REG_W-1:0]   write_reg;
  logic               write;
  logic               move;
  logic               mem_to_reg;
  logic               mem_write;
  logic               branch;
  logic               immediate;
  logic               set_quarter;
  logic               jump_sign;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal;
  logic               halted;

  modport master (
    output in_valid, instruction_in, flush, out_ready,
    input  in_ready, out_valid, read_reg0, read_reg1, write_reg, write, move,
           mem_to_reg, mem_write, branch, immediate, set_quarter, jump_sign,
           alu_op, illegal, halted
  );

  modport slave (
    input  in_valid, instruction_in, flush, out_ready,
    output in_ready, out_valid, read_reg0, read_reg1, write_reg, write, move,
           mem_to_reg, mem_write, branch, immediate, set_quarter, jump_sign,
           alu_op, illegal, halted
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: instruction -> control bundle, with load-use bubble, flush and sticky halt.
//
// state       | meaning
// S_RUN       | normal issue
// S_STALL     | load-use bubble was just inserted; tracker already cleared
// S_HALT_PEND | halt bundle issued, waiting for execute to consume it
// S_HALTED    | core halted, only rst_n leaves this state
module decode_ctrl_stage #(
  parameter int INSTR_W = 9,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4
) (
  input logic clk,
  input logic rst_n,
  decode_ctrl_stage_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT_PEND, S_HALTED} state_t;

  typedef struct packed {
    logic [REG_W-1:0]   rr0;
    logic [REG_W-1:0]   rr1;
    logic [REG_W-1:0]   wr;
    logic               write;
    logic               move;
    logic               m2r;
    logic               mw;
    logic               branch;
    logic               imm;
    logic               sq;
    logic               js;
    logic [ALUOP_W-1:0] alu;
    logic               illegal;
  } ctrl_t;

  localparam logic [REG_W-1:0] R_ADR  = REG_W'(4);
  localparam logic [REG_W-1:0] R_MATH = REG_W'(5);
  localparam logic [REG_W-1:0] R_CNT  = REG_W'(7);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, dec;
  logic             out_valid_q, out_valid_d;
  logic             trk_vld_q, trk_vld_d;
  logic [REG_W-1:0] trk_q, trk_d;
  logic             alive_q;

  logic [4:0]       op;
  logic [3:0]       fld;
  logic [REG_W-1:0] fhi, flo;
  logic             use0, use1, is_ld, is_halt;
  logic             hazard, in_ready, accept;

  assign op  = bus.instruction_in[INSTR_W-1 -: 5];
  assign fld = bus.instruction_in[3:0];
  assign fhi = REG_W'(fld[3:2]);
  assign flo = REG_W'(fld[1:0]);

  // use0/use1 mark opcodes whose read_reg fields are real sources (for hazard detection)
  always_comb begin
    dec  = '0;
    use0 = 1'b0;
    use1 = 1'b0;
    case (op)
      5'h00, 5'h01: begin
        dec.rr0 = fhi; dec.rr1 = R_MATH; dec.wr = flo; dec.write = 1'b1;
        dec.alu = ALUOP_W'(op); use0 = 1'b1; use1 = 1'b1;
      end
      5'h02: begin dec.rr0 = fhi; dec.wr = flo; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h03: begin dec.rr0 = fhi; dec.wr = R_ADR; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h04: begin dec.rr0 = R_ADR; dec.wr = flo; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h05: begin dec.wr = R_ADR; dec.write = 1'b1; dec.imm = 1'b1; dec.js = fld[0]; end
      5'h06: begin dec.rr0 = REG_W'(fld); dec.wr = R_MATH; dec.write = 1'b1; dec.imm = 1'b1; use0 = 1'b1; end
      5'h07: begin dec.rr0 = R_MATH; dec.wr = flo; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h08: begin dec.rr0 = fhi; dec.wr = R_MATH; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h09, 5'h0A: begin
        dec.rr0 = R_MATH; dec.rr1 = fhi; dec.wr = (op == 5'h09) ? R_ADR : flo;
        dec.write = 1'b1; dec.move = 1'b1; dec.sq = 1'b1; use0 = 1'b1; use1 = 1'b1;
      end
      5'h0B: begin
        dec.rr0 = flo; dec.rr1 = fhi; dec.wr = R_CNT; dec.write = 1'b1; dec.sq = 1'b1;
        use0 = 1'b1; use1 = 1'b1;
      end
      5'h0C: begin dec.rr0 = R_CNT; dec.wr = flo; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h0D: begin dec.rr0 = fhi; dec.wr = R_CNT; dec.write = 1'b1; dec.move = 1'b1; use0 = 1'b1; end
      5'h0E: begin dec.wr = R_CNT; dec.write = 1'b1; dec.imm = 1'b1; end
      5'h0F, 5'h10, 5'h11, 5'h12, 5'h13: begin
        dec.rr0 = fhi; dec.rr1 = flo; dec.branch = 1'b1; use0 = 1'b1; use1 = 1'b1;
        case (op)
          5'h0F:   dec.alu = ALUOP_W'(7);
          5'h10:   dec.alu = ALUOP_W'(8);
          5'h11:   dec.alu = ALUOP_W'(6);
          5'h12:   dec.alu = ALUOP_W'(5);
          default: dec.alu = ALUOP_W'(4);
        endcase
      end
      5'h14, 5'h15: begin
        dec.rr0 = fhi; dec.wr = flo; use0 = 1'b1;
        dec.alu = (op == 5'h14) ? ALUOP_W'(2) : ALUOP_W'(3);
      end
      5'h16: begin
        dec.rr0 = fhi; dec.rr1 = R_ADR; dec.wr = flo; dec.write = 1'b1; dec.m2r = 1'b1;
        use0 = 1'b1; use1 = 1'b1;
      end
      5'h17: begin
        dec.rr0 = fhi; dec.rr1 = R_ADR; dec.wr = flo; dec.mw = 1'b1; use0 = 1'b1; use1 = 1'b1;
      end
      5'h18: begin dec.branch = 1'b1; dec.alu = ALUOP_W'(7); end
      5'h19: begin dec.wr = flo; dec.write = 1'b1; dec.imm = 1'b1; end
      5'h1A: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign is_ld   = (op == 5'h16);
  assign is_halt = (op == 5'h1A);

  assign hazard = trk_vld_q & bus.in_valid &
                  ((use0 & (dec.rr0 == trk_q)) | (use1 & (dec.rr1 == trk_q)));

  // alive_q holds in_ready low while rst_n is asserted and for the first edge after release
  assign in_ready = alive_q & ((state_q == S_RUN) | (state_q == S_STALL)) & ~hazard &
                    (~out_valid_q | bus.out_ready) & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    trk_vld_d   = trk_vld_q;
    trk_d       = trk_q;
    if (bus.flush && state_q != S_HALTED) begin
      state_d     = S_RUN;
      out_valid_d = 1'b0;
      trk_vld_d   = 1'b0;
    end else begin
      if (accept) begin
        ctrl_d      = dec;
        out_valid_d = 1'b1;
        trk_vld_d   = is_ld;
        trk_d       = dec.wr;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        S_RUN: begin
          if (accept && is_halt) begin
            state_d = S_HALT_PEND;
          end else if (hazard) begin
            state_d   = S_STALL;
            trk_vld_d = 1'b0;
          end
        end
        S_STALL:     state_d = (accept && is_halt) ? S_HALT_PEND : S_RUN;
        S_HALT_PEND: if (out_valid_q && bus.out_ready) state_d = S_HALTED;
        default:     state_d = S_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      trk_vld_q   <= 1'b0;
      trk_q       <= '0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      trk_vld_q   <= trk_vld_d;
      trk_q       <= trk_d;
      alive_q     <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.read_reg0   = ctrl_q.rr0;
  assign bus.read_reg1   = ctrl_q.rr1;
  assign bus.write_reg   = ctrl_q.wr;
  assign bus.write       = ctrl_q.write;
  assign bus.move        = ctrl_q.move;
  assign bus.mem_to_reg  = ctrl_q.m2r;
  assign bus.mem_write   = ctrl_q.mw;
  assign bus.branch      = ctrl_q.branch;
  assign bus.immediate   = ctrl_q.imm;
  assign bus.set_quarter = ctrl_q.sq;
  assign bus.jump_sign   = ctrl_q.js;
  assign bus.alu_op      = ctrl_q.alu;
  assign bus.illegal     = ctrl_q.illegal;
  assign bus.halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: behavioural model checked every cycle plus directed literal checks.
module tb_decode_ctrl_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_ctrl_stage_if bus();
  decode_ctrl_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // bundle = {rr0, rr1, wr, write, move, m2r, mw, branch, imm, sq, js, alu, illegal}
  function automatic logic [24:0] mdl(input logic [8:0] ins, output bit u0, output bit u1);
    int op, a, b, f, r0, r1, wr, alu;
    bit w, mv, m2r, mw, br, im, sq, js, il;
    int balu[5] = '{7, 8, 6, 5, 4};
    op = int'(ins[8:4]); a = int'(ins[3:2]); b = int'(ins[1:0]); f = int'(ins[3:0]);
    r0 = 0; r1 = 0; wr = 0; alu = 0;
    {w, mv, m2r, mw, br, im, sq, js, il} = '0;
    u0 = 0; u1 = 0;
    if (op <= 1) begin
      r0 = a; r1 = 5; wr = b; w = 1; alu = op; u0 = 1; u1 = 1;
    end else if (op >= 15 && op <= 19) begin
      r0 = a; r1 = b; br = 1; alu = balu[op-15]; u0 = 1; u1 = 1;
    end else if (op >= 27) begin
      il = 1;
    end else begin
      case (op)
        2:  begin r0 = a; wr = b; w = 1; mv = 1; u0 = 1; end
        3:  begin r0 = a; wr = 4; w = 1; mv = 1; u0 = 1; end
        4:  begin r0 = 4; wr = b; w = 1; mv = 1; u0 = 1; end
        5:  begin wr = 4; w = 1; im = 1; js = ins[0]; end
        6:  begin r0 = f; wr = 5; w = 1; im = 1; u0 = 1; end
        7:  begin r0 = 5; wr = b; w = 1; mv = 1; u0 = 1; end
        8:  begin r0 = a; wr = 5; w = 1; mv = 1; u0 = 1; end
        9:  begin r0 = 5; r1 = a; wr = 4; w = 1; mv = 1; sq = 1; u0 = 1; u1 = 1; end
        10: begin r0 = 5; r1 = a; wr = b; w = 1; mv = 1; sq = 1; u0 = 1; u1 = 1; end
        11: begin r0 = b; r1 = a; wr = 7; w = 1; sq = 1; u0 = 1; u1 = 1; end
        12: begin r0 = 7; wr = b; w = 1; mv = 1; u0 = 1; end
        13: begin r0 = a; wr = 7; w = 1; mv = 1; u0 = 1; end
        14: begin wr = 7; w = 1; im = 1; end
        20: begin r0 = a; wr = b; alu = 2; u0 = 1; end
        21: begin r0 = a; wr = b; alu = 3; u0 = 1; end
        22: begin r0 = a; r1 = 4; wr = b; w = 1; m2r = 1; u0 = 1; u1 = 1; end
        23: begin r0 = a; r1 = 4; wr = b; mw = 1; u0 = 1; u1 = 1; end
        24: begin br = 1; alu = 7; end
        25: begin wr = b; w = 1; im = 1; end
        default: ;
      endcase
    end
    return {4'(r0), 4'(r1), 4'(wr), w, mv, m2r, mw, br, im, sq, js, 4'(alu), il};
  endfunction

  logic [24:0] dut_b;
  assign dut_b = {bus.read_reg0, bus.read_reg1, bus.write_reg, bus.write, bus.move,
                  bus.mem_to_reg, bus.mem_write, bus.branch, bus.immediate, bus.set_quarter,
                  bus.jump_sign, bus.alu_op, bus.illegal};

  // model: mode 0=issuing, 1=just bubbled, 2=halt waiting to be consumed, 3=halted
  int          m_mode = 0;
  int          m_trk = -1;
  bit          m_alive = 0;
  bit          m_valid = 0;
  logic [24:0] m_b = '0;
  logic [24:0] e_dec;
  bit          e_u0, e_u1, e_haz, e_ir, e_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_trk = -1; m_alive = 0; m_valid = 0; m_b = '0;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_bundle", 32'(dut_b), 0);
    end else begin
      e_dec = mdl(bus.instruction_in, e_u0, e_u1);
      e_haz = bus.in_valid && m_trk >= 0 &&
              ((e_u0 && int'(e_dec[24:21]) == m_trk) || (e_u1 && int'(e_dec[20:17]) == m_trk));
      e_ir  = m_alive && m_mode <= 1 && !e_haz && (!m_valid || bus.out_ready) && !bus.flush;
      e_acc = bus.in_valid && e_ir;
      chk("in_ready", 32'(bus.in_ready), 32'(e_ir));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("halted", 32'(bus.halted), 32'(m_mode == 3));
      if (m_valid) chk("bundle", 32'(dut_b), 32'(m_b));
      m_alive = 1;
      if (bus.flush && m_mode != 3) begin
        m_valid = 0; m_trk = -1; m_mode = 0;
      end else if (e_acc) begin
        m_b = e_dec; m_valid = 1;
        m_trk = (bus.instruction_in[8:4] == 5'h16) ? int'(e_dec[16:13]) : -1;
        m_mode = (bus.instruction_in[8:4] == 5'h1A) ? 2 : 0;
      end else begin
        if (m_mode == 0 && e_haz) begin m_mode = 1; m_trk = -1; end
        else if (m_mode == 1) m_mode = 0;
        else if (m_mode == 2 && m_valid && bus.out_ready) m_mode = 3;
        if (bus.out_ready) m_valid = 0;
      end
    end
  end

  task automatic send(input logic [8:0] ins, output int stalls);
    int n;
    bit done;
    n = 0; done = 0; stalls = 0;
    bus.in_valid = 1'b1; bus.instruction_in = ins;
    while (!done && n < 20) begin
      @(negedge clk);
      if (bus.in_ready) done = 1; else stalls++;
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: instr 0x%0h not accepted in 20 cycles", ins);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int st, tot;
  logic [8:0] stream [6] = '{9'h006, 9'h0AB, 9'h050, 9'h130, 9'h0B6, 9'h141};
  logic [8:0] ri;

  initial begin
    bus.in_valid = 1'b0; bus.instruction_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_at_release", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release", 32'(bus.in_ready), 1);

    send(9'h006, st);
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_r0", 32'(bus.read_reg0), 1);
    chk("add_r1", 32'(bus.read_reg1), 5);
    chk("add_wr", 32'(bus.write_reg), 2);
    chk("add_write", 32'(bus.write), 1);
    chk("add_alu", 32'(bus.alu_op), 0);

    tot = 0;
    foreach (stream[i]) begin send(stream[i], st); tot += st; end
    chk("stream_stalls", 32'(tot), 0);

    send(9'h1F0, st);
    chk("ill_flag", 32'(bus.illegal), 1);
    chk("ill_write", 32'(bus.write), 0);
    chk("ill_memw", 32'(bus.mem_write), 0);
    chk("ill_branch", 32'(bus.branch), 0);
    send(9'h180, st);
    chk("jump_branch", 32'(bus.branch), 1);
    chk("jump_alu", 32'(bus.alu_op), 7);
    chk("jump_write", 32'(bus.write), 0);

    send(9'h166, st);
    send(9'h00B, st);
    chk("ld_use_stalls", 32'(st), 1);
    chk("ld_use_r0", 32'(bus.read_reg0), 2);
    send(9'h166, st);
    send(9'h007, st);
    chk("ld_nouse_stalls", 32'(st), 0);

    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instruction_in = 9'h0E5;
    repeat (3) @(posedge clk);
    #1;
    chk("held_wr", 32'(bus.write_reg), 3);
    chk("held_r1", 32'(bus.read_reg1), 5);
    chk("held_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    send(9'h0E5, st);
    chk("resume_wr", 32'(bus.write_reg), 7);
    chk("resume_imm", 32'(bus.immediate), 1);

    for (int op = 0; op < 32; op++) begin
      if (op != 26) send({5'(op), 4'(op * 3)}, st);
    end

    for (int c = 0; c < 200; c++) begin
      ri = 9'($urandom_range(0, 511));
      if (ri[8:4] == 5'h1A) ri[8:4] = 5'h16;
      bus.instruction_in = ri;
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    idle(2);

    bus.out_ready = 1'b0;
    send(9'h1A0, st);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_halted", 32'(bus.halted), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    send(9'h006, st);
    chk("after_flush_stalls", 32'(st), 0);

    send(9'h1A0, st);
    @(posedge clk); #1;
    chk("halt_set", 32'(bus.halted), 1);
    bus.in_valid = 1'b1; bus.instruction_in = 9'h006;
    repeat (2) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("halt_sticky", 32'(bus.halted), 1);
    chk("halt_in_ready", 32'(bus.in_ready), 0);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_halted", 32'(bus.halted), 0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 0);
    chk("async_rst_write", 32'(bus.write), 0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    send(9'h006, st);
    chk("post_rst_r1", 32'(bus.read_reg1), 5);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
